led_chase_decoder: RTL and testbench

- Monitor/decoder for a one-hot LED chaser pattern; the receiving end of the LED bus that the chaser drives.
- Samples a WIDTH-bit one-hot LED vector and recovers the binary lit position and the sweep direction.
- Counts end-of-sweep reversals, and flags malformed patterns, position jumps and stalls.
- Sits beside the chaser on CLOCK_50 in self-check builds and drives status LEDs/HEX logic.

---
 rtl/led_chase_decoder.sv | 204 ++++++++++++++++++++
 tb/tb_led_chase_decoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_chase_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : led_chase_decoder
//  Brief    : Recovers position/direction from a one-hot LED chaser bus and
//             flags malformed patterns, jumps and stalls.
//             Optional LED_CHASE_RANGE_CHECK_EN enables the reversal-range check.
//  Revision : 1.0  initial release
// ============================================================================
module led_chase_decoder #(
  parameter int WIDTH     = 10,
  parameter int POS_W     = 4,
  parameter int STALL_W   = 20,
  parameter int STALL_MAX = 2**20-1,
  parameter int LO_END    = 1,
  parameter int HI_END    = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic [WIDTH-1:0]  led_in,
  input  logic              clear_err,
  output logic [POS_W-1:0]  pos,
  output logic              pos_valid,
  output logic              dir,
  output logic              step_strobe,
  output logic              bounce_strobe,
  output logic [7:0]        bounce_count,
  output logic              err_onehot,
  output logic              err_jump,
  output logic              err_range,
  output logic              stall
);

  localparam logic [0:0]         c_st_acquire = 1'b0;
  localparam logic [0:0]         c_st_track   = 1'b1;
  localparam logic [STALL_W-1:0] c_stall_max  = STALL_W'(STALL_MAX);
  localparam logic signed [POS_W:0] c_diff_one = {{POS_W{1'b0}}, 1'b1};

  if ((2**POS_W) < WIDTH || LO_END >= HI_END || HI_END >= WIDTH) begin : g_param_check
    $error("led_chase_decoder: inconsistent WIDTH/POS_W/LO_END/HI_END");
  end

  logic [WIDTH-1:0]        r_sync1;
  logic [WIDTH-1:0]        r_s2;
  logic [WIDTH-1:0]        r_prev;
  logic [0:0]              r_state;
  logic [0:0]              w_state_nxt;
  logic [POS_W-1:0]        r_pos;
  logic                    r_dir;
  logic                    r_dir_known;
  logic                    r_step;
  logic                    r_bounce;
  logic [7:0]              r_bounce_cnt;
  logic                    r_err_onehot;
  logic                    r_err_jump;
  logic [STALL_W-1:0]      r_stall_cnt;

  logic                    w_change;
  logic                    w_ok;
  logic [POS_W-1:0]        w_idx;
  logic signed [POS_W:0]   w_diff;
  logic                    w_up;
  logic                    w_dn;
  logic                    w_pos_valid;
  logic                    w_acquire;
  logic                    w_step;
  logic                    w_jump;
  logic                    w_bad;
  logic                    w_bounce;

  // led_in is asynchronous to us; two flops before anything looks at it
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= '0;
      r_s2    <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= led_in;
      r_s2    <= r_sync1;
      r_prev  <= r_s2;
    end
  end

  assign w_change = (r_s2 != r_prev);
  assign w_ok     = (r_s2 != '0) && ((r_s2 & (r_s2 - WIDTH'(1))) == '0);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_s2[i]) w_idx = POS_W'(i);
    end
  end

  assign w_diff = $signed({1'b0, w_idx}) - $signed({1'b0, r_pos});
  assign w_up   = (w_diff == c_diff_one);
  assign w_dn   = (w_diff == '1);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_state <= c_st_acquire;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_acquire: if (w_ok) w_state_nxt = c_st_track;
      c_st_track:   if (w_change && !w_ok) w_state_nxt = c_st_acquire;
      default:      w_state_nxt = c_st_acquire;
    endcase
  end

  always_comb begin
    w_pos_valid = 1'b0;
    w_acquire   = 1'b0;
    w_step      = 1'b0;
    w_jump      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      c_st_acquire: w_acquire = w_ok;
      c_st_track: begin
        w_pos_valid = 1'b1;
        if (w_change) begin
          if (!w_ok)              w_bad  = 1'b1;
          else if (w_up || w_dn)  w_step = 1'b1;
          else if (w_diff != '0)  w_jump = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A reversal needs a known previous direction; the first step after acquire only learns it
  assign w_bounce = w_step && r_dir_known && (w_up != r_dir);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pos        <= '0;
      r_dir        <= 1'b0;
      r_dir_known  <= 1'b0;
      r_step       <= 1'b0;
      r_bounce     <= 1'b0;
      r_bounce_cnt <= '0;
      r_err_onehot <= 1'b0;
      r_err_jump   <= 1'b0;
    end else begin
      r_step   <= w_step;
      r_bounce <= w_bounce;
      if (w_acquire) begin
        r_pos       <= w_idx;
        r_dir_known <= 1'b0;
      end else if (w_step) begin
        r_pos       <= w_idx;
        r_dir       <= w_up;
        r_dir_known <= 1'b1;
      end else if (w_jump) begin
        r_pos       <= w_idx;
      end
      if (w_bounce && (r_bounce_cnt != 8'hFF)) r_bounce_cnt <= r_bounce_cnt + 8'd1;
      r_err_onehot <= w_bad  | (r_err_onehot & ~clear_err);
      r_err_jump   <= w_jump | (r_err_jump   & ~clear_err);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_stall_cnt <= '0;
    end else if ((r_state == c_st_acquire) || w_change) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != c_stall_max) begin
      r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

`ifdef LED_CHASE_RANGE_CHECK_EN
  localparam logic [POS_W-1:0] c_lo_end = POS_W'(LO_END);
  localparam logic [POS_W-1:0] c_hi_end = POS_W'(HI_END);

  logic r_err_range;
  logic w_range_bad;

  // r_pos is still the pre-step position while the bounce is being decided
  assign w_range_bad = w_bounce && (r_pos != c_lo_end) && (r_pos != c_hi_end);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_err_range <= 1'b0;
    else          r_err_range <= w_range_bad | (r_err_range & ~clear_err);
  end

  assign err_range = r_err_range;
`else
  assign err_range = 1'b0;
`endif

  assign pos           = r_pos;
  assign pos_valid     = w_pos_valid;
  assign dir           = r_dir;
  assign step_strobe   = r_step;
  assign bounce_strobe = r_bounce;
  assign bounce_count  = r_bounce_cnt;
  assign err_onehot    = r_err_onehot;
  assign err_jump      = r_err_jump;
  assign stall         = (r_stall_cnt == c_stall_max);

endmodule
`default_nettype wire

// File: tb/tb_led_chase_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_chase_decoder
//  Brief    : Directed self-checking bench for led_chase_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_led_chase_decoder;

  localparam int WIDTH = 10;
  localparam int POS_W = 4;

  logic             CLOCK_50 = 1'b0;
  logic             RESET_N  = 1'b0;
  logic [WIDTH-1:0] led_in   = 10'h001;
  logic             clear_err = 1'b0;
  logic [POS_W-1:0] pos;
  logic             pos_valid;
  logic             dir;
  logic             step_strobe;
  logic             bounce_strobe;
  logic [7:0]       bounce_count;
  logic             err_onehot;
  logic             err_jump;
  logic             err_range;
  logic             stall;

  int n_total = 0;
  int n_bad   = 0;
  int n_step_seen   = 0;
  int n_bounce_seen = 0;
  int step_base;
  int bounce_base;
  int exp_range;

  led_chase_decoder #(
    .WIDTH     (WIDTH),
    .POS_W     (POS_W),
    .STALL_W   (20),
    .STALL_MAX (100),
    .LO_END    (1),
    .HI_END    (8)
  ) u_dut (
    .CLOCK_50      (CLOCK_50),
    .RESET_N       (RESET_N),
    .led_in        (led_in),
    .clear_err     (clear_err),
    .pos           (pos),
    .pos_valid     (pos_valid),
    .dir           (dir),
    .step_strobe   (step_strobe),
    .bounce_strobe (bounce_strobe),
    .bounce_count  (bounce_count),
    .err_onehot    (err_onehot),
    .err_jump      (err_jump),
    .err_range     (err_range),
    .stall         (stall)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Strobe pulses counted on the falling edge, so a stretched pulse counts twice
  always @(negedge CLOCK_50) begin
    if (step_strobe)   n_step_seen++;
    if (bounce_strobe) n_bounce_seen++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic hold(input logic [WIDTH-1:0] v, input int n);
    led_in = v;
    tick(n);
  endtask

  task automatic hold_bit(input int k, input int n);
    logic [WIDTH-1:0] v;
    v = '0;
    v[k] = 1'b1;
    hold(v, n);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    chk("rst_pos_valid", pos_valid, 0);
    chk("rst_pos", pos, 0);
    chk("rst_bounce_count", bounce_count, 0);
    chk("rst_errs", {err_onehot, err_jump, err_range}, 0);
    chk("rst_stall", stall, 0);

    RESET_N = 1'b1;
    tick(2);
    chk("acq_latency_early", pos_valid, 0);
    tick(1);
    chk("acq_pos_valid", pos_valid, 1);
    chk("acq_pos", pos, 0);
    chk("acq_dir", dir, 0);
    chk("acq_errs", {err_onehot, err_jump, err_range}, 0);
    chk("acq_no_strobes", n_step_seen + n_bounce_seen, 0);

    // Upward sweep
    hold_bit(1, 16);
    chk("first_step_dir", dir, 1);
    chk("first_step_no_bounce", n_bounce_seen, 0);
    step_base = n_step_seen;
    for (int k = 2; k <= 8; k++) hold_bit(k, 16);
    chk("up_steps", n_step_seen - step_base, 7);
    chk("up_pos", pos, 8);
    chk("up_dir", dir, 1);
    chk("up_bounce_count", bounce_count, 0);

    // Reversal at the top end
    bounce_base = n_bounce_seen;
    hold_bit(7, 16);
    chk("top_rev_dir", dir, 0);
    chk("top_rev_pos", pos, 7);
    chk("top_rev_bounce_count", bounce_count, 1);
    chk("top_rev_pulses", n_bounce_seen - bounce_base, 1);
    for (int k = 6; k >= 1; k--) hold_bit(k, 16);
    chk("down_pos", pos, 1);
    chk("down_bounce_count", bounce_count, 1);
    hold_bit(2, 16);
    chk("low_rev_bounce_count", bounce_count, 2);
    chk("low_rev_dir", dir, 1);
    hold_bit(3, 16);

    // Jump 3 -> 6 with clear_err landing on the same edge as the error
    step_base = n_step_seen;
    led_in = 10'h040;
    tick(2);
    chk("jump_latency_early", err_jump, 0);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    chk("jump_set_wins", err_jump, 1);
    chk("jump_pos", pos, 6);
    chk("jump_dir", dir, 1);
    tick(15);
    chk("jump_no_step", n_step_seen - step_base, 0);
    chk("jump_sticky", err_jump, 1);
    pulse_clear();
    chk("jump_cleared", err_jump, 0);
    chk("jump_still_valid", pos_valid, 1);

    // Malformed patterns
    hold(10'h000, 16);
    chk("blank_err_onehot", err_onehot, 1);
    chk("blank_pos_valid", pos_valid, 0);
    chk("blank_pos_held", pos, 6);
    hold(10'h018, 16);
    chk("multi_pos_valid", pos_valid, 0);
    chk("multi_err_onehot", err_onehot, 1);
    pulse_clear();
    chk("onehot_cleared", err_onehot, 0);
    bounce_base = n_bounce_seen;
    hold(10'h020, 16);
    chk("reacq_pos", pos, 5);
    chk("reacq_pos_valid", pos_valid, 1);
    led_in = 10'h010;
    tick(3);
    chk("reacq_step_pos", pos, 4);
    chk("reacq_step_dir", dir, 0);
    chk("reacq_no_bounce", n_bounce_seen - bounce_base, 0);
    chk("reacq_bounce_count", bounce_count, 2);

    // Stall: last change event was the edge just sampled
    tick(99);
    chk("stall_early", stall, 0);
    tick(1);
    chk("stall_at_max", stall, 1);
    tick(5);
    chk("stall_holds", stall, 1);
    led_in = 10'h020;
    tick(2);
    chk("stall_before_change", stall, 1);
    tick(1);
    chk("stall_dropped", stall, 0);
    chk("mid_rev_bounce_count", bounce_count, 3);

    // Reversal at pos 5, away from both ends
    tick(13);
    pulse_clear();
    chk("range_cleared", err_range, 0);
    hold(10'h010, 16);
    chk("range_bounce_count", bounce_count, 4);
`ifdef LED_CHASE_RANGE_CHECK_EN
    exp_range = 1;
`else
    exp_range = 0;
`endif
    chk("range_flag", err_range, exp_range);

    // Asynchronous reset mid-operation
    RESET_N = 1'b0;
    #2;
    chk("async_rst_bounce_count", bounce_count, 0);
    chk("async_rst_pos_valid", pos_valid, 0);
    chk("async_rst_pos", pos, 0);
    chk("async_rst_errs", {err_onehot, err_jump, err_range}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
